// File: rtl/sync_event_arbiter.sv
// sync_event_arbiter
//   Collects rising edges on four pre-synchronized event lines into per-channel
//   pending flags and hands them one at a time to a consumer over a four-phase
//   req/ack handshake. Channels are served round-robin, starting after the last
//   granted channel. Events that arrive while their channel is already pending
//   coalesce and raise a sticky overflow flag.
//
// Ports
//   out_clk   : clock, all state changes on the rising edge
//   clr       : asynchronous active-high reset
//   sync_in   : per-channel event lines, already synchronous to out_clk
//   evt_ack   : consumer acknowledge (four-phase)
//   ovf_clr   : synchronous clear of all overflow flags
//   evt_req   : event request to the consumer (registered)
//   evt_id    : granted channel, valid while evt_req=1, held otherwise
//   pending   : per-channel pending-event flags
//   overflow  : sticky per-channel lost-event flags
module sync_event_arbiter (
  input  logic       out_clk,
  input  logic       clr,
  input  logic [3:0] sync_in,
  input  logic       evt_ack,
  input  logic       ovf_clr,
  output logic       evt_req,
  output logic [1:0] evt_id,
  output logic [3:0] pending,
  output logic [3:0] overflow
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRel} state_e;

  state_e     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] overflow_q, overflow_d;
  logic [1:0] evt_id_q, evt_id_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic       evt_req_q, evt_req_d;

  logic [3:0] rise;
  logic [3:0] done_vec;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  // Edge detection, pending and overflow bookkeeping.
  always_comb begin
    prev_d   = sync_in;
    rise     = sync_in & ~prev_q;
    done_vec = 4'b0000;
    if (state_q == StReq && evt_ack) begin
      done_vec[evt_id_q] = 1'b1;
    end
    // A rise coinciding with its own completion re-arms the channel without loss.
    pending_d  = rise | (pending_q & ~done_vec);
    // Set wins over ovf_clr for the same bit.
    overflow_d = (overflow_q & {4{~ovf_clr}}) | (rise & pending_q & ~done_vec);
  end

  // Round-robin pick: first pending channel after last_grant, with wrap.
  always_comb begin
    pick  = last_grant_q;
    idx   = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant_q + k[1:0];
      if (!found && pending_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Handshake FSM next state.
  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          evt_id_d = pick;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (evt_ack) begin
          last_grant_d = evt_id_q;
          state_d      = StWaitRel;
        end
      end
      StWaitRel: begin
        if (!evt_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    evt_req_d = (state_d == StReq);
  end

  always_ff @(posedge out_clk or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      prev_q       <= 4'b0000;
      pending_q    <= 4'b0000;
      overflow_q   <= 4'b0000;
      evt_id_q     <= 2'd0;
      last_grant_q <= 2'd3;  // so channel 0 is searched first after reset
      evt_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      evt_req_q    <= evt_req_d;
    end
  end

  assign evt_req  = evt_req_q;
  assign evt_id   = evt_id_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// tb_sync_event_arbiter
//   Self-checking bench for sync_event_arbiter: a directed vector table, a few
//   hand-written multi-cycle sequences, and randomized stimulus compared each
//   cycle against a behavioural reference model.
module tb_sync_event_arbiter;

  logic       out_clk;
  logic       clr;
  logic [3:0] sync_in;
  logic       evt_ack;
  logic       ovf_clr;
  logic       evt_req;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic [3:0] overflow;

  sync_event_arbiter dut (
    .out_clk  (out_clk),
    .clr      (clr),
    .sync_in  (sync_in),
    .evt_ack  (evt_ack),
    .ovf_clr  (ovf_clr),
    .evt_req  (evt_req),
    .evt_id   (evt_id),
    .pending  (pending),
    .overflow (overflow)
  );

  initial out_clk = 1'b0;
  always #5 out_clk = ~out_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: 0 = idle, 1 = requesting, 2 = waiting for release.
  logic [3:0] m_prev, m_pend, m_ovf;
  int         m_state, m_id, m_last;
  bit         m_req;

  task automatic model_reset();
    m_prev  = 4'b0;
    m_pend  = 4'b0;
    m_ovf   = 4'b0;
    m_state = 0;
    m_id    = 0;
    m_last  = 3;
    m_req   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic a, input logic oc);
    int         done;
    int         nstate;
    int         c;
    bit         got;
    logic [3:0] np, no;
    done = (m_state == 1 && a) ? m_id : -1;
    np   = m_pend;
    no   = oc ? 4'b0 : m_ovf;
    for (int i = 0; i < 4; i++) begin
      if (s[i] && !m_prev[i]) begin
        if (m_pend[i] && done != i) no[i] = 1'b1;
        np[i] = 1'b1;
      end else if (done == i) begin
        np[i] = 1'b0;
      end
    end
    nstate = m_state;
    if (m_state == 0) begin
      if (m_pend != 4'b0) begin
        got = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!got && m_pend[c]) begin
            m_id = c;
            got  = 1'b1;
          end
        end
        nstate = 1;
      end
    end else if (m_state == 1) begin
      if (a) begin
        m_last = m_id;
        nstate = 2;
      end
    end else begin
      if (!a) nstate = 0;
    end
    m_state = nstate;
    m_pend  = np;
    m_ovf   = no;
    m_prev  = s;
    m_req   = (nstate == 1);
  endtask

  function automatic logic [10:0] dut_vec();
    return {evt_req, evt_id, pending, overflow};
  endfunction

  function automatic logic [10:0] model_vec();
    logic [1:0] id;
    id = m_id[1:0];
    return {m_req, id, m_pend, m_ovf};
  endfunction

  task automatic check_vec(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got req=%0b id=%0d pend=%b ovf=%b, expected req=%0b id=%0d pend=%b ovf=%b",
               name, $time, act[10], act[9:8], act[7:4], act[3:0],
               exp[10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock cycle with the given inputs, then compare against the model.
  task automatic step(input logic [3:0] s, input logic a, input logic oc);
    sync_in = s;
    evt_ack = a;
    ovf_clr = oc;
    @(posedge out_clk);
    model_step(s, a, oc);
    #1;
    check_vec("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(posedge out_clk);
    #1;
    model_reset();
    check_vec("reset", dut_vec(), model_vec());
    clr = 1'b0;
  endtask

  typedef struct {
    logic       clr;
    logic [3:0] s;
    logic       a;
    logic       oc;
    logic       req;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic [3:0] s, input logic a, input logic oc,
                     input logic req, input logic [1:0] id, input logic [3:0] pend,
                     input logic [3:0] ovf);
    vec_t v;
    v.clr = c; v.s = s; v.a = a; v.oc = oc;
    v.req = req; v.id = id; v.pend = pend; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  initial begin
    int grants;
    bit last_req;

    clr     = 1'b1;
    sync_in = 4'b0;
    evt_ack = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    #2;
    check_vec("async_reset_state", dut_vec(), 11'b0);
    do_reset();

    // Single event round trip, then all four channels, then channels 0 and 3.
    add(0, 4'b0001, 0, 0, 0, 2'd0, 4'b0001, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd0, 4'b0001, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0);
    add(1, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 4'b0);
    add(0, 4'b1111, 0, 0, 0, 2'd0, 4'b1111, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd0, 4'b1111, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd0, 4'b1110, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd0, 4'b1110, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd1, 4'b1110, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd1, 4'b1100, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd1, 4'b1100, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd2, 4'b1100, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd2, 4'b1000, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd2, 4'b1000, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd3, 4'b1000, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd3, 4'b0000, 4'b0);
    add(0, 4'b1001, 0, 0, 0, 2'd3, 4'b1001, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd0, 4'b1001, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd0, 4'b1000, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd0, 4'b1000, 4'b0);
    add(0, 4'b0000, 0, 0, 1, 2'd3, 4'b1000, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0);
    add(0, 4'b0000, 0, 0, 0, 2'd3, 4'b0000, 4'b0);
    add(0, 4'b0000, 1, 0, 0, 2'd3, 4'b0000, 4'b0);  // ack in idle is ignored
    add(0, 4'b0000, 0, 0, 0, 2'd3, 4'b0000, 4'b0);

    foreach (tbl[n]) begin
      clr     = tbl[n].clr;
      sync_in = tbl[n].s;
      evt_ack = tbl[n].a;
      ovf_clr = tbl[n].oc;
      @(posedge out_clk);
      if (tbl[n].clr) model_reset();
      else model_step(tbl[n].s, tbl[n].a, tbl[n].oc);
      #1;
      check_vec($sformatf("table[%0d]", n), dut_vec(),
                {tbl[n].req, tbl[n].id, tbl[n].pend, tbl[n].ovf});
    end
    clr = 1'b0;

    // Channel 2 pulses twice while its request waits: one grant, overflow set.
    do_reset();
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);
    check_vec("ovf_wait", dut_vec(), {1'b1, 2'd2, 4'b0100, 4'b0100});
    step(4'b0000, 1, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    check_vec("ovf_single_grant", dut_vec(), {1'b0, 2'd2, 4'b0000, 4'b0100});
    step(4'b0000, 0, 1);
    check_int("ovf_clr", int'(overflow), 0);

    // Same-cycle overflow set beats ovf_clr.
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0100, 0, 1);
    check_int("ovf_set_wins", int'(overflow), 4);
    step(4'b0000, 1, 1);
    step(4'b0000, 0, 0);

    // Channel 1 rises in the same cycle as its ack: re-armed, no overflow.
    do_reset();
    step(4'b0010, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0010, 1, 0);
    check_vec("rise_on_ack", dut_vec(), {1'b0, 2'd1, 4'b0010, 4'b0000});
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    check_vec("regrant_ch1", dut_vec(), {1'b1, 2'd1, 4'b0010, 4'b0000});
    step(4'b0000, 1, 0);
    step(4'b0000, 0, 0);

    // Asynchronous clear mid-handshake, with channels 0 and 2 held high.
    do_reset();
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    check_int("pre_clr_req", int'(evt_req), 1);
    sync_in = 4'b0101;
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_vec("async_clr", dut_vec(), 11'b0);
    @(posedge out_clk);
    #1;
    clr = 1'b0;
    step(4'b0101, 0, 0);
    check_int("held_high_is_rise", int'(pending), 5);
    step(4'b0101, 0, 0);
    check_vec("first_grant_ch0", dut_vec(), {1'b1, 2'd0, 4'b0101, 4'b0000});
    step(4'b0000, 1, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 1, 0);
    step(4'b0000, 0, 0);

    // Channel 3 held high for ten cycles: one event only.
    do_reset();
    grants   = 0;
    last_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step((c < 10) ? 4'b1000 : 4'b0000, evt_req, 0);
      if (evt_req && !last_req) grants++;
      last_req = evt_req;
    end
    check_int("held_level_grants", grants, 1);
    check_int("held_level_ovf", int'(overflow), 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_event_arbiter.md
SYNC_EVENT_ARBITER -- requirements
Module: sync_event_arbiter

Interface
REQ-001 The block SHALL have the port out_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port sync_in, input, 4 bits: per-channel event lines, each already synchronized to out_clk by an upstream synchronizer.
REQ-004 The block SHALL have the port evt_ack, input, 1 bit: consumer acknowledge, four-phase handshake.
REQ-005 The block SHALL have the port ovf_clr, input, 1 bit: synchronous clear of all overflow bits.
REQ-006 The block SHALL have the port evt_req, output, 1 bit: event request to the consumer.
REQ-007 The block SHALL have the port evt_id, output, 2 bits: the granted channel; valid while evt_req=1.
REQ-008 The block SHALL have the port pending, output, 4 bits: per-channel pending-event flags.
REQ-009 The block SHALL have the port overflow, output, 4 bits: sticky per-channel lost-event flags.

Function
REQ-010 Edge detect SHALL register sync_in into prev[3:0] each cycle; rise[i] = sync_in[i] & ~prev[i]; a level held high for several cycles SHALL count as one event.
REQ-011 rise[i] sampled at edge k SHALL set pending[i]=1 after edge k.
REQ-012 rise[i] while pending[i]=1 and channel i is not completing that cycle SHALL set overflow[i]=1; pending[i] stays 1 (events coalesce).
REQ-013 A channel completes in the cycle where state=REQ, evt_id=i and evt_ack=1; completion SHALL clear pending[i] at that edge.
REQ-014 rise[i] in the same cycle as completion of channel i SHALL leave pending[i]=1 and SHALL NOT set overflow[i].
REQ-015 The FSM SHALL have three states: IDLE, REQ, WAIT_REL.
REQ-016 In IDLE with pending!=0, the FSM SHALL select the first pending channel searching from (last_grant+1) mod 4 upward with wrap, latch it into evt_id, and enter REQ at the next edge.
REQ-017 In IDLE with pending=0, the FSM SHALL remain in IDLE.
REQ-018 In REQ, evt_req SHALL be 1 and evt_id SHALL be stable.
REQ-019 In REQ with evt_ack=1, the FSM SHALL load last_grant=evt_id and enter WAIT_REL.
REQ-020 In REQ with evt_ack=0, the FSM SHALL remain in REQ indefinitely, with no timeout.
REQ-021 In WAIT_REL, evt_req SHALL be 0; evt_ack=0 SHALL return the FSM to IDLE; otherwise it stays in WAIT_REL.
REQ-022 evt_req SHALL be a registered output equal to (state==REQ).
REQ-023 evt_ack in IDLE SHALL be ignored.
REQ-024 Latency: isolated rise sampled at edge k SHALL give evt_req=1 after edge k+1.
REQ-025 ovf_clr=1 SHALL clear all overflow bits at the next edge.
REQ-026 A same-cycle overflow set SHALL win over ovf_clr for that bit.
REQ-027 evt_id SHALL hold its last value outside REQ.

Reset
REQ-028 clr=1 SHALL immediately, without waiting for out_clk, force state=IDLE, evt_req=0, evt_id=0, pending=0, overflow=0, prev=0, last_grant=3 (channel 0 highest priority first).
REQ-029 clr asserted mid-handshake SHALL drop evt_req at once and discard all pending events.
REQ-030 After clr falls, a sync_in already high SHALL be treated as a new rise at the first edge.

Verification
REQ-031 Reset, then sync_in=0001 for 1 cycle -> pending=0001 after edge 1; evt_req=1 with evt_id=0 after edge 2; ack pulse clears pending, evt_req=0, and the FSM returns to IDLE after ack=0.
REQ-032 sync_in=1111 in one cycle, ack each request promptly -> grant order 0,1,2,3; a repeat sync_in=1001 pulse -> order 0,3.
REQ-033 Channel 2 pulses twice while its request is waiting for ack -> overflow=0100 and a single grant; ovf_clr=1 -> overflow=0000.
REQ-034 Channel 1 pulse in the same cycle as its ack -> pending[1] remains 1, overflow[1]=0, and channel 1 is re-granted.
REQ-035 clr asserted between clock edges while evt_req=1 -> evt_req=0 before the next edge, pending=0000, and the first grant after reset goes to channel 0.
REQ-036 sync_in[3] held high for 10 cycles -> exactly one grant and overflow=0000.
